// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the MII receive path.
// CRC parameters follow IEEE 802.3 reflected CRC-32.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  localparam int BCNT_W = 11;
  localparam int PCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 update, LSB of the byte first.
// Purely combinational.
import eth_pkg::*;

module eth_crc32 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY;
      else      c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_mii.sv
// MII receiver: preamble/SFD sync, nibble-to-byte assembly,
// per-byte FCS check and a single terminating strobe per frame.
import eth_pkg::*;

module eth_rx_mii #(
  parameter int MIN_PRE_NIB = 4,
  parameter int MAX_LEN     = 1530
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  output logic [7:0] data_out,
  output logic       data_out_vld,
  output logic       byte_out_vld,
  output logic       crc_vld
);

  localparam logic [PCNT_W-1:0] MIN_PRE =
    PCNT_W'(MIN_PRE_NIB);
  localparam logic [BCNT_W-1:0] MAX_CNT =
    BCNT_W'(MAX_LEN);

  rx_state_e state_q, state_d;

  logic [PCNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic              phase_q, phase_d;
  logic              dv_q, dv_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              dvld_q, dvld_d;
  logic              bvld_q, bvld_d;
  logic              crcv_q, crcv_d;

  logic              term;
  logic              take;
  logic [7:0]        rx_byte;
  logic [31:0]       crc_next;

  assign rx_byte = {mii_rxd, lo_nib_q};

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .byte_in (rx_byte),
    .crc_out (crc_next)
  );

  // dv_q resets high so a frame already in flight is never joined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC_INIT;
      lo_nib_q   <= '0;
      phase_q    <= 1'b0;
      dv_q       <= 1'b1;
      data_out_q <= '0;
      dvld_q     <= 1'b0;
      bvld_q     <= 1'b0;
      crcv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      lo_nib_q   <= lo_nib_d;
      phase_q    <= phase_d;
      dv_q       <= dv_d;
      data_out_q <= data_out_d;
      dvld_q     <= dvld_d;
      bvld_q     <= bvld_d;
      crcv_q     <= crcv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mii_rx_dv) begin
          if (mii_rxd == PRE_NIB && !mii_rx_er && !dv_q)
            state_d = PRE;
          else
            state_d = DROP;
        end
      end
      PRE: begin
        if (!mii_rx_dv)
          state_d = IDLE;
        else if (mii_rx_er)
          state_d = DROP;
        else if (mii_rxd == SFD_NIB && pre_cnt_q >= MIN_PRE)
          state_d = DATA;
        else if (mii_rxd != PRE_NIB)
          state_d = DROP;
      end
      DATA: begin
        if (!mii_rx_dv || mii_rx_er || byte_cnt_q >= MAX_CNT) begin
          term    = 1'b1;
          state_d = mii_rx_dv ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!mii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    lo_nib_d   = lo_nib_q;
    phase_d    = phase_q;
    dv_d       = mii_rx_dv;
    data_out_d = '0;
    dvld_d     = (state_d == DATA);
    bvld_d     = 1'b0;
    crcv_d     = 1'b0;
    take       = (state_q == DATA) && !term;

    if (state_q == IDLE && state_d == PRE)
      pre_cnt_d = PCNT_W'(1);
    if (state_q == PRE && mii_rxd == PRE_NIB && pre_cnt_q != '1)
      pre_cnt_d = pre_cnt_q + 1'b1;

    if (state_q == PRE && state_d == DATA) begin
      phase_d    = 1'b0;
      byte_cnt_d = '0;
      crc_d      = CRC_INIT;
    end

    if (take && !phase_q) begin
      lo_nib_d = mii_rxd;
      phase_d  = 1'b1;
    end

    if (take && phase_q) begin
      phase_d    = 1'b0;
      crc_d      = crc_next;
      data_out_d = rx_byte;
      bvld_d     = 1'b1;
      crcv_d     = (crc_next == CRC_RESIDUE);
      if (byte_cnt_q != '1)
        byte_cnt_d = byte_cnt_q + 1'b1;
    end

    if (term) begin
      phase_d = 1'b0;
      bvld_d  = 1'b1;
    end
  end

  assign data_out     = data_out_q;
  assign data_out_vld = dvld_q;
  assign byte_out_vld = bvld_q;
  assign crc_vld      = crcv_q;

endmodule

// File: doc/eth_rx_mii.md
ETH_RX_MII -- requirements
Module: eth_rx_mii

Interface
REQ-001 Parameter MIN_PRE_NIB, default 4, minimum count of 0x5 preamble nibbles before SFD accepted.
REQ-002 Parameter MAX_LEN, default 1530, maximum post-SFD byte count before the frame is dropped.
REQ-003 clk  input  1  MII receive clock (25 MHz); all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mii_rxd  input  4  MII receive nibble, least significant nibble of each byte first.
REQ-006 mii_rx_dv  input  1  MII receive data valid.
REQ-007 mii_rx_er  input  1  MII receive error.
REQ-008 data_out  output  8  assembled byte, {second nibble, first nibble}.
REQ-009 data_out_vld  output  1  high while a frame is in progress (post-SFD, not dropped).
REQ-010 byte_out_vld  output  1  one-cycle strobe qualifying data_out, data_out_vld and crc_vld.
REQ-011 crc_vld  output  1  high with byte_out_vld when FCS check passes on that byte.

Function
REQ-012 The FSM SHALL have states IDLE, PRE, DATA, DROP.
REQ-013 IDLE: mii_rx_dv=1 and mii_rxd=0x5 -> PRE (preamble count=1); other nibble with dv=1 -> DROP.
REQ-014 PRE: 0x5 increments the saturating preamble count; 0xD with count>=MIN_PRE_NIB -> DATA, nibble phase 0, byte count 0, CRC reg 0xFFFFFFFF; any other nibble, 0xD with count<MIN_PRE_NIB, dv=0 or rx_er=1 -> DROP (dv=0 -> IDLE).
REQ-015 DATA phase 0: latch nibble as low nibble; phase 1: form byte, assert byte_out_vld and data_out_vld in the following cycle with data_out = byte (latency one clk from high nibble sample).
REQ-016 CRC SHALL be IEEE 802.3 reflected (poly 0xEDB88320, LSB first), updated once per assembled byte including FCS bytes.
REQ-017 crc_vld SHALL assert with byte_out_vld when the CRC register after including that byte equals residue 0xDEBB20E3; otherwise 0.
REQ-018 Frame end: dv falling in DATA (either phase), rx_er=1 in DATA, or byte count reaching MAX_LEN SHALL produce one terminating strobe: byte_out_vld=1, data_out_vld=0, crc_vld=0, data_out=0x00, next cycle.
REQ-019 After termination: dv=0 -> IDLE; dv still 1 -> DROP.
REQ-020 A dangling phase-0 nibble at dv fall SHALL be discarded, never emitted.
REQ-021 DROP: all outputs 0; exit to IDLE only when dv=0 sampled.
REQ-022 byte_out_vld SHALL never assert on consecutive cycles except data-byte followed by terminating strobe.
REQ-023 Byte counter 11 bits, saturating; no wrap.

Reset
REQ-024 rst_n=0 SHALL force state IDLE, counters 0, CRC reg 0xFFFFFFFF, data_out=0, data_out_vld=0, byte_out_vld=0, crc_vld=0, no terminating strobe.
REQ-025 Reset mid-frame SHALL abandon the frame; if dv still 1 after release, the block SHALL go to DROP, not resynchronise mid-frame.

Structure
REQ-026 Package eth_pkg SHALL hold CRC polynomial, residue, init value, preamble nibble 0x5, SFD nibble 0xD and the state enum.
REQ-027 Sub-module eth_crc32 SHALL implement the byte-wide CRC update (crc_in, byte_in -> crc_out), combinational.

Verification
REQ-028 8x0x5, 0xD, bytes "123456789" (0x31..0x39), FCS 26 39 F4 CB, dv fall -> 13 data strobes, data_out 0x31 first, crc_vld=1 only on 0xCB, then one terminating strobe.
REQ-029 Same frame, FCS last byte 0xCA -> crc_vld never 1; terminating strobe after 0xCA.
REQ-030 Preamble of 2x0x5 then 0xD (MIN_PRE_NIB=4) -> DROP, no strobes until dv low; next good frame received normally.
REQ-031 mii_rx_er=1 at byte 5 -> 4 data strobes, terminating strobe, no further output until dv low.
REQ-032 dv falls after an odd nibble -> partial nibble discarded, terminating strobe only.
REQ-033 MAX_LEN=16, 20-byte frame -> 16 data strobes, terminating strobe, DROP until dv low; rst_n pulse mid-frame -> outputs 0 next cycle, DROP.
